// File: rtl/led_pkg.sv
// Shared mode encodings, widths and default timing for the status-LED scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pkg;

    localparam int MODE_W = 3;
    localparam int CNT_W  = 25;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF        = 3'd0,
        MODE_STEADY     = 3'd1,
        MODE_BREATH     = 3'd2,
        MODE_BLINK_SLOW = 3'd3,
        MODE_BLINK_FAST = 3'd4
    } mode_t;

    localparam logic [7:0] DEF_LOW_TH    = 8'd20;
    localparam logic [7:0] DEF_CRIT_TH   = 8'd5;
    localparam logic [7:0] DEF_HYST      = 8'd5;
    localparam int         DEF_MIN_HOLD  = 200;
    localparam int         DEF_SLOW_HALF = 50;
    localparam int         DEF_FAST_HALF = 10;
    localparam int         DEF_PWM_STEPS = 16;

    // Flag release level; 9 bits so threshold + hysteresis never wraps.
    function automatic logic [8:0] clear_level(input logic [7:0] th, input logic [7:0] hyst);
        return {1'b0, th} + {1'b0, hyst};
    endfunction

endpackage

// File: rtl/led_breath_pwm.sv
// Breathing engine: PWM counter with a triangle-stepped duty (0..STEPS-1..0), one period per step.
// Latency: pwm_out is the combinational level for the coming edge, so the parent can register it in step with the counters.
// Backpressure: none; advances every cycle while enable is high, restart forces duty 0 / direction up. Debug ports under LED_DEBUG_EN.
module led_breath_pwm
    import led_pkg::*;
#(
    parameter  int PWM_STEPS = DEF_PWM_STEPS,
    localparam int PW        = $clog2(PWM_STEPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          restart,
    input  logic          enable,
    output logic          pwm_out
`ifdef LED_DEBUG_EN
    ,
    output logic [PW-1:0] duty,
    output logic [PW-1:0] pwm_cnt
`endif
);

    localparam logic [PW-1:0] TOP = PW'(PWM_STEPS - 1);
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0] cnt_q, cnt_n;
    logic [PW-1:0] duty_q, duty_n;
    logic          dir_dn_q, dir_dn_n;

    always_comb begin
        cnt_n    = cnt_q;
        duty_n   = duty_q;
        dir_dn_n = dir_dn_q;
        if (restart) begin
            cnt_n    = '0;
            duty_n   = '0;
            dir_dn_n = 1'b0;
        end else if (enable) begin
            if (cnt_q == TOP) begin
                cnt_n = '0;
                // Direction flips as the endpoint is entered, so each endpoint lasts one period.
                if (dir_dn_q) begin
                    duty_n = duty_q - ONE;
                    if (duty_q == ONE) dir_dn_n = 1'b0;
                end else begin
                    duty_n = duty_q + ONE;
                    if (duty_q == TOP - ONE) dir_dn_n = 1'b1;
                end
            end else begin
                cnt_n = cnt_q + ONE;
            end
        end
    end

    assign pwm_out = (cnt_n < duty_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            duty_q   <= '0;
            dir_dn_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_n;
            duty_q   <= duty_n;
            dir_dn_q <= dir_dn_n;
        end
    end

`ifdef LED_DEBUG_EN
    assign duty    = duty_q;
    assign pwm_cnt = cnt_q;
`endif

endmodule

// File: rtl/led_pattern_scheduler.sv
// Status-LED owner: battery flags with hysteresis, fixed-priority arbitration with minimum dwell, blink/breath generation.
// Latency: mode, led and mode_change all update on the edge where the grant condition holds; battery flags add one cycle.
// Backpressure: none; level inputs sampled every 100 Hz tick. LED_DEBUG_EN adds dwell_cnt/phase_cnt outputs.
module led_pattern_scheduler
    import led_pkg::*;
#(
    parameter logic [7:0] LOW_TH    = DEF_LOW_TH,
    parameter logic [7:0] CRIT_TH   = DEF_CRIT_TH,
    parameter logic [7:0] HYST      = DEF_HYST,
    parameter int         MIN_HOLD  = DEF_MIN_HOLD,
    parameter int         SLOW_HALF = DEF_SLOW_HALF,
    parameter int         FAST_HALF = DEF_FAST_HALF,
    parameter int         PWM_STEPS = DEF_PWM_STEPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        battery,
    input  logic              charging,
    input  logic              fan_state,
    input  logic              fault,
    output logic              led,
    output logic [MODE_W-1:0] mode,
    output logic              mode_change
`ifdef LED_DEBUG_EN
    ,
    output logic [CNT_W-1:0]  dwell_cnt,
    output logic [CNT_W-1:0]  phase_cnt
`endif
);

    localparam int         MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int         BW       = $clog2(2 * MAX_HALF);
    localparam int         PW       = $clog2(PWM_STEPS);
    localparam logic [8:0] LOW_CLR  = clear_level(LOW_TH, HYST);
    localparam logic [8:0] CRIT_CLR = clear_level(CRIT_TH, HYST);
    localparam logic [BW-1:0]    B_ONE = BW'(1);
    localparam logic [CNT_W-1:0] D_ONE = CNT_W'(1);

    mode_t             mode_q, req, mode_n;
    logic              low_q, crit_q;
    logic              armed_q;
    logic [CNT_W-1:0]  dwell_q;
    logic [BW-1:0]     blink_q, blink_n;
    logic              grant, brth_pwm, led_n;

    function automatic logic [BW-1:0] half_of(input mode_t m);
        return (m == MODE_BLINK_FAST) ? BW'(FAST_HALF) : BW'(SLOW_HALF);
    endfunction

    always_comb begin
        if (fault || (crit_q && !charging)) req = MODE_BLINK_FAST;
        else if (charging)                  req = MODE_BREATH;
        else if (low_q)                     req = MODE_BLINK_SLOW;
        else if (fan_state)                 req = MODE_STEADY;
        else                                req = MODE_OFF;
    end

    // The post-reset OFF was never granted, so it carries no dwell obligation.
    assign grant  = (req != mode_q) &&
                    ((req == MODE_BLINK_FAST) || !armed_q || (dwell_q >= CNT_W'(MIN_HOLD - 1)));
    assign mode_n = grant ? req : mode_q;

    always_comb begin
        blink_n = '0;
        if (!grant && (mode_q == MODE_BLINK_SLOW || mode_q == MODE_BLINK_FAST))
            blink_n = (blink_q == (half_of(mode_q) << 1) - B_ONE) ? '0 : blink_q + B_ONE;
    end

    always_comb begin
        case (mode_n)
            MODE_STEADY:                      led_n = 1'b1;
            MODE_BREATH:                      led_n = brth_pwm;
            MODE_BLINK_SLOW, MODE_BLINK_FAST: led_n = (blink_n < half_of(mode_n));
            default:                          led_n = 1'b0;
        endcase
    end

`ifdef LED_DEBUG_EN
    logic [PW-1:0] brth_duty, brth_cnt;
`endif

    led_breath_pwm #(.PWM_STEPS(PWM_STEPS)) u_breath (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (grant),
        .enable  (mode_q == MODE_BREATH),
        .pwm_out (brth_pwm)
`ifdef LED_DEBUG_EN
        ,
        .duty    (brth_duty),
        .pwm_cnt (brth_cnt)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_q       <= 1'b0;
            crit_q      <= 1'b0;
            mode_q      <= MODE_OFF;
            armed_q     <= 1'b0;
            dwell_q     <= '0;
            blink_q     <= '0;
            mode_change <= 1'b0;
            led         <= 1'b0;
        end else begin
            if (battery <= CRIT_TH)                crit_q <= 1'b1;
            else if ({1'b0, battery} >= CRIT_CLR)  crit_q <= 1'b0;
            if (battery <= LOW_TH)                 low_q  <= 1'b1;
            else if ({1'b0, battery} >= LOW_CLR)   low_q  <= 1'b0;

            if (grant) begin
                mode_q  <= req;
                armed_q <= 1'b1;
                dwell_q <= '0;
            end else if (dwell_q != '1) begin
                dwell_q <= dwell_q + D_ONE;
            end
            mode_change <= grant;
            blink_q     <= blink_n;
            led         <= led_n;
        end
    end

    assign mode = mode_q;

`ifdef LED_DEBUG_EN
    assign dwell_cnt = dwell_q;
    always_comb begin
        case (mode_q)
            MODE_BREATH:                      phase_cnt = CNT_W'({brth_duty, brth_cnt});
            MODE_BLINK_SLOW, MODE_BLINK_FAST: phase_cnt = CNT_W'(blink_q);
            default:                          phase_cnt = '0;
        endcase
    end
`endif

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Scoreboard bench: every grant is predicted (mode, edge, first led level) when stimulus is driven, then matched on mode_change.
module tb_led_pattern_scheduler;
    import led_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  battery;
    logic        charging, fan_state, fault;
    logic        led, mode_change;
    logic [2:0]  mode;
`ifdef LED_DEBUG_EN
    logic [CNT_W-1:0] dwell_cnt, phase_cnt;
`endif

    led_pattern_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .battery     (battery),
        .charging    (charging),
        .fan_state   (fan_state),
        .fault       (fault),
        .led         (led),
        .mode        (mode),
        .mode_change (mode_change)
`ifdef LED_DEBUG_EN
        ,
        .dwell_cnt   (dwell_cnt),
        .phase_cnt   (phase_cnt)
`endif
    );

    typedef struct {
        logic [2:0] mode;
        int         at;
        logic       led;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic [2:0] m, input int at, input logic l);
        sb_q.push_back('{m, at, l});
    endtask

    // Each grant is popped and checked just after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (mode_change === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_mode_change", 32'(mode_change), 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                chk("grant_mode",  32'(mode), 32'(sb_e.mode));
                chk("grant_cycle", 32'(cyc),  32'(sb_e.at));
                chk("grant_led",   32'(led),  32'(sb_e.led));
            end
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            chk("grant_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic count_high(input int start, input int len, output int hi);
        hi = 0;
        for (int i = 0; i < len; i++) begin
            wait_until(start + i);
            hi += int'(led);
        end
    endtask

    function automatic int breath_duty(input int p);
        int k = p % 30;
        return (k <= 15) ? k : 30 - k;
    endfunction

    initial begin
        int g, b, s, t, b2, f, r, g2, r2, e, c, hi;

        rst_n = 1'b0; battery = 8'd50; charging = 1'b0; fan_state = 1'b1; fault = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_led",         32'(led),         32'd0);
        chk("reset_mode",        32'(mode),        32'd0);
        chk("reset_mode_change", 32'(mode_change), 32'd0);

        // Leaving the reset OFF state needs no dwell.
        c = cyc;
        rst_n = 1'b1;
        push(MODE_STEADY, c + 1, 1'b1);
        drain(10);
        g = c + 1;

        // Short charging blip inside the dwell window must not move the mode.
        wait_until(g + 10); charging = 1'b1;
        wait_until(g + 13); charging = 1'b0;
        wait_until(g + 50); charging = 1'b1;
        push(MODE_BREATH, g + 200, 1'b0);
        drain(300);
        b = g + 200;
        for (int p = 0; p < 32; p++) begin
            count_high(b + 16 * p, 16, hi);
            chk("breath_duty", 32'(hi), 32'(breath_duty(p)));
        end

        // Low battery: 21 is above threshold, 20 sets the flag.
        wait_until(b + 512); battery = 8'd21;
        wait_until(b + 514); battery = 8'd20;
        wait_until(b + 516); charging = 1'b0;
        push(MODE_BLINK_SLOW, b + 517, 1'b1);
        drain(10);
        s = b + 517;
        count_high(s, 50, hi);      chk("slow_on_half",  32'(hi), 32'd50);
        count_high(s + 50, 50, hi); chk("slow_off_half", 32'(hi), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_until(s + 100 + 2 * i);
            battery = 8'(21 + i);
        end
        wait_until(s + 110); battery = 8'd25;
        push(MODE_STEADY, (s + 112 > s + 200) ? s + 112 : s + 200, 1'b1);
        drain(300);
        t = s + 200;

        // Fault preempts a young BREATH grant immediately.
        wait_until(t + 5); charging = 1'b1;
        push(MODE_BREATH, t + 200, 1'b0);
        drain(300);
        b2 = t + 200;
        wait_until(b2 + 10); fault = 1'b1;
        push(MODE_BLINK_FAST, b2 + 11, 1'b1);
        drain(10);
        f = b2 + 11;
        for (int h = 0; h < 4; h++) begin
            count_high(f + 10 * h, 10, hi);
            chk("fast_half", 32'(hi), (h % 2 == 0) ? 32'd10 : 32'd0);
        end
        wait_until(f + 40); fault = 1'b0;
        push(MODE_BREATH, f + 200, 1'b0);
        drain(300);
        r = f + 200;
        count_high(r, 16, hi);      chk("breath_restart_p0", 32'(hi), 32'd0);
        count_high(r + 16, 16, hi); chk("breath_restart_p1", 32'(hi), 32'd1);

        // Critical battery: flag lands one cycle later, then preempts.
        wait_until(r + 40); battery = 8'd4; charging = 1'b0;
        push(MODE_BLINK_FAST, r + 42, 1'b1);
        drain(10);
        g2 = r + 42;
        wait_until(g2 + 20); charging = 1'b1;
        push(MODE_BREATH, g2 + 200, 1'b0);
        drain(300);
        r2 = g2 + 200;

        // Asynchronous reset in the middle of a fast blink.
        wait_until(r2 + 5); fault = 1'b1;
        push(MODE_BLINK_FAST, r2 + 6, 1'b1);
        drain(10);
        e = r2 + 6;
        wait_until(e + 7);
        chk("fast_phase7_led", 32'(led), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_mode", 32'(mode), 32'd0);
        chk("async_reset_led",  32'(led),  32'd0);
        fault = 1'b0; charging = 1'b0; fan_state = 1'b0; battery = 8'd50;
        @(negedge clk); rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_mode", 32'(mode), 32'd0);
        chk("idle_led",  32'(led),  32'd0);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
